// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating multiplexer with a registered valid/ready output stage.
// Define ARB_MUX_PACKET_EN to hold the grant on one channel until its in_last beat.
module rr_arb_mux #(
  parameter int WIDTH = 16,
  parameter int N = 4,
  localparam int CW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [CW-1:0]      out_chan,
  input  logic               out_ready
);

  logic [CW-1:0]    ptr;
  logic [CW-1:0]    grant_idx;
  logic [CW-1:0]    next_ptr;
  logic             grant_valid;
  logic             load;
  logic [N-1:0]     eligible;
  logic [WIDTH-1:0] sel_data;

`ifdef ARB_MUX_PACKET_EN
  logic          lock;
  logic [CW-1:0] lock_chan;

  // While a packet is open only its owner may be granted.
  always_comb begin
    eligible = in_valid;
    if (lock) eligible = in_valid & ({{(N-1){1'b0}}, 1'b1} << lock_chan);
  end
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign eligible    = in_valid;
`endif

  assign load = !out_valid || out_ready;

  // Search from ptr upward, wrapping at N-1 so non-power-of-two N never indexes past N-1.
  always_comb begin
    logic [CW:0]   sum;
    logic [CW-1:0] pos;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    pos         = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (CW+1)'(k);
      if (sum >= (CW+1)'(N)) sum = sum - (CW+1)'(N);
      pos = sum[CW-1:0];
      if (!grant_valid && eligible[pos]) begin
        grant_valid = 1'b1;
        grant_idx   = pos;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == CW'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (load && grant_valid && !rst) in_ready[grant_idx] = 1'b1;
  end

  assign next_ptr = (grant_idx == CW'(N-1)) ? '0 : grant_idx + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
`ifdef ARB_MUX_PACKET_EN
      lock      <= 1'b0;
      lock_chan <= '0;
`endif
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= grant_idx;
`ifdef ARB_MUX_PACKET_EN
        // Fairness rotation happens only once a packet has closed.
        if (in_last[grant_idx]) begin
          ptr  <= next_ptr;
          lock <= 1'b0;
        end else begin
          lock      <= 1'b1;
          lock_chan <= grant_idx;
        end
`else
        ptr <= next_ptr;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
